// File: rtl/fd_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and constants for the fetch/decode queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [XLEN-1:0] inst;
    } fd_entry_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fd_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fd_if
//  Description : Fetch-side and decode-side handshake bundle of fd_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fd_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            f_valid;
    logic            f_ready;
    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] f_next_pc;
    logic [XLEN-1:0] f_inst;
    logic            d_valid;
    logic            d_ready;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_next_pc;
    logic [XLEN-1:0] d_inst;
    logic [CW-1:0]   count;

    modport master (
        output flush, f_valid, f_pc, f_next_pc, f_inst, d_ready,
        input  f_ready, d_valid, d_pc, d_next_pc, d_inst, count
    );

    modport slave (
        input  flush, f_valid, f_pc, f_next_pc, f_inst, d_ready,
        output f_ready, d_valid, d_pc, d_next_pc, d_inst, count
    );
endinterface : fd_if
`default_nettype wire

// File: rtl/fd_queue_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Read/write pointers and occupancy counter of a circular FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  wire logic          clk_in,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic          i_clr,
    output logic [PW-1:0]      o_rptr,
    output logic [PW-1:0]      o_wptr,
    output logic [CW-1:0]      o_cnt,
    output logic               o_full,
    output logic               o_empty
);

    logic [PW-1:0] r_rptr_q, w_rptr_d;
    logic [PW-1:0] r_wptr_q, w_wptr_d;
    logic [CW-1:0] r_cnt_q,  w_cnt_d;

    always_comb begin
        w_rptr_d = r_rptr_q;
        w_wptr_d = r_wptr_q;
        w_cnt_d  = r_cnt_q;
        if (i_clr) begin
            w_rptr_d = '0;
            w_wptr_d = '0;
            w_cnt_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
            if (i_push) w_wptr_d = r_wptr_q + PW'(1);
            if (i_pop)  w_rptr_d = r_rptr_q + PW'(1);
            case ({i_push, i_pop})
                2'b10:   w_cnt_d = r_cnt_q + CW'(1);
                2'b01:   w_cnt_d = r_cnt_q - CW'(1);
                default: w_cnt_d = r_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_rptr_q <= '0;
            r_wptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_rptr_q <= w_rptr_d;
            r_wptr_q <= w_wptr_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign o_rptr  = r_rptr_q;
    assign o_wptr  = r_wptr_q;
    assign o_cnt   = r_cnt_q;
    assign o_full  = (r_cnt_q == CW'(DEPTH));
    assign o_empty = (r_cnt_q == '0);

endmodule : fifo_ctrl
`default_nettype wire

// File: rtl/fd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fd_queue
//  Description : FWFT fetch-to-decode instruction queue with one-cycle flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fd_queue #(
    parameter int              XLEN        = core_pkg::XLEN,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] NOP_INST    = core_pkg::NOP_INST,
    parameter bit              ZERO_AS_NOP = 1'b1
) (
    input  wire logic clk_in,
    input  wire logic rst,
    fd_if.slave       bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] w_rptr;
    logic [PW-1:0] w_wptr;
    logic [CW-1:0] w_cnt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    core_pkg::fd_entry_t r_mem_q [DEPTH];
    core_pkg::fd_entry_t w_mem_d;
    core_pkg::fd_entry_t w_head;

    assign w_push = bus.f_valid & ~w_full  & ~bus.flush;
    assign w_pop  = bus.d_ready & ~w_empty & ~bus.flush;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clr   (bus.flush),
        .o_rptr  (w_rptr),
        .o_wptr  (w_wptr),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_mem_d.pc      = bus.f_pc;
        w_mem_d.next_pc = bus.f_next_pc;
        w_mem_d.inst    = (ZERO_AS_NOP && (bus.f_inst == '0)) ? NOP_INST : bus.f_inst;
    end

    // Storage carries no reset: emptiness is tracked by the counter alone.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem_q[w_wptr] <= w_mem_d;
    end

    always_comb begin
        w_head        = r_mem_q[w_rptr];
        bus.d_pc      = '0;
        bus.d_next_pc = '0;
        bus.d_inst    = NOP_INST;
        if (!w_empty) begin
            bus.d_pc      = w_head.pc;
            bus.d_next_pc = w_head.next_pc;
            bus.d_inst    = w_head.inst;
        end
    end

    assign bus.f_ready = ~w_full;
    assign bus.d_valid = ~w_empty;
    assign bus.count   = w_cnt;

endmodule : fd_queue
`default_nettype wire
